// File: rtl/costas_acq_ctrl.sv
// Costas loop acquisition/tracking sequencer: windowed lock metric, gain select, NCO sweep.
// Latency: state and outputs update 2 cycles after the last sample strobe of a window.
// Backpressure: none; every sample_valid is consumed. Optional stats ports: COSTAS_ACQ_STATS_EN.
module costas_acq_ctrl #(
    parameter int DATA_W      = 8,
    parameter int WIN_LOG2    = 4,
    parameter int Q_SHIFT     = 2,
    parameter int MIN_AMP     = 16,
    parameter int LOCK_CNT    = 3,
    parameter int UNLOCK_CNT  = 2,
    parameter int ACQ_TIMEOUT = 4,
    parameter int SWEEP_STEP  = 100,
    parameter int SWEEP_STEPS = 2,
    parameter int FREQ_W      = 16,
    parameter int KP_ACQ      = 3,
    parameter int KI_ACQ      = 6,
    parameter int KP_TRK      = 6,
    parameter int KI_TRK      = 10
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic signed [DATA_W-1:0] q_data,
    output logic [3:0]               kp_shift,
    output logic [3:0]               ki_shift,
    output logic signed [FREQ_W-1:0] freq_offset,
    output logic                     freq_offset_load,
    output logic                     locked,
    output logic [1:0]               state,
    output logic                     win_done
`ifdef COSTAS_ACQ_STATS_EN
    ,
    output logic [15:0]              lock_loss_cnt,
    output logic [7:0]               sweep_wrap_cnt
`endif
);

    localparam int WIN     = 1 << WIN_LOG2;
    localparam int MAG_W   = DATA_W - 1;
    localparam int ACC_W   = DATA_W - 1 + WIN_LOG2;
    localparam int CNT_W   = WIN_LOG2 + 1;
    localparam int SW_LAST = 2 * SWEEP_STEPS;
    localparam int IDX_W   = $clog2(SW_LAST + 2);
    localparam int GC_W    = $clog2(LOCK_CNT + 1);
    localparam int BC_W    = $clog2(UNLOCK_CNT + 1);
    localparam int TO_W    = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SW_LAST);
    localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(LOCK_CNT - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(UNLOCK_CNT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACQ_TIMEOUT - 1);
    localparam logic [31:0]      MIN_THR  = 32'(MIN_AMP) << WIN_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_PULL  = 2'd2,
        S_TRACK = 2'd3
    } st_t;

    // Magnitude with the most negative code clamped so it fits in DATA_W-1 bits.
    function automatic logic [MAG_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] m;
        m = x[DATA_W-1] ? (~x + 1'b1) : x;
        if (m[DATA_W-1]) begin
            return {MAG_W{1'b1}};
        end
        return m[MAG_W-1:0];
    endfunction

    // Sweep index k maps to 0, +S, -S, +2S, -2S, ...: odd k positive, even k negative.
    function automatic logic [FREQ_W-1:0] sweep_off(input logic [IDX_W-1:0] idx);
        int mag;
        mag = (int'(idx) + 1) / 2;
        if (idx[0]) begin
            return FREQ_W'(mag * SWEEP_STEP);
        end
        return FREQ_W'(-(mag * SWEEP_STEP));
    endfunction

    // Registered state and outputs
    st_t                state_q;
    logic               en_q;
    logic [GC_W-1:0]    gc_q;
    logic [BC_W-1:0]    bc_q;
    logic [TO_W-1:0]    to_q;
    logic [IDX_W-1:0]   idx_q;
    logic [FREQ_W-1:0]  fo_q;
    logic               ld_q;
    logic               lk_q;
    logic [3:0]         kp_q;
    logic [3:0]         ki_q;

    // Window datapath
    logic [ACC_W-1:0]   acc_i;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   smp_cnt;
    logic               eval_q;
    logic               run;
    logic [ACC_W-1:0]   mag_i;
    logic [ACC_W-1:0]   mag_q;
    logic               good;
    logic               eval;

    // Next-state values
    st_t                st_n;
    logic [GC_W-1:0]    gc_n;
    logic [BC_W-1:0]    bc_n;
    logic [TO_W-1:0]    to_n;
    logic [IDX_W-1:0]   idx_n;
    logic [FREQ_W-1:0]  fo_n;
    logic               ld_n;

    assign run   = enable && (state_q != S_IDLE);
    assign mag_i = ACC_W'(sat_abs(i_data));
    assign mag_q = ACC_W'(sat_abs(q_data));
    assign eval  = eval_q && enable;
    assign good  = (acc_q <= (acc_i >> Q_SHIFT)) && (32'(acc_i) >= MIN_THR);

    // Accumulate |I|,|Q| over the window; the evaluation cycle restarts the sums
    // so a strobe coinciding with it opens the next window.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !run) begin
            acc_i   <= '0;
            acc_q   <= '0;
            smp_cnt <= '0;
            eval_q  <= 1'b0;
        end else begin
            eval_q <= sample_valid && (smp_cnt == CNT_LAST);
            if (sample_valid) begin
                smp_cnt <= (smp_cnt == CNT_LAST) ? '0 : smp_cnt + 1'b1;
                acc_i   <= (eval_q ? '0 : acc_i) + mag_i;
                acc_q   <= (eval_q ? '0 : acc_q) + mag_q;
            end else if (eval_q) begin
                acc_i <= '0;
                acc_q <= '0;
            end
        end
    end

    // Next state: transitions happen only on evaluation, except leaving IDLE.
    always_comb begin
        st_n  = state_q;
        gc_n  = gc_q;
        bc_n  = bc_q;
        to_n  = to_q;
        idx_n = idx_q;
        fo_n  = fo_q;
        ld_n  = 1'b0;
        if (!enable) begin
            st_n = S_IDLE;
            gc_n = '0;
            bc_n = '0;
            to_n = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en_q) begin
                        st_n = S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (eval) begin
                        if (good) begin
                            st_n = (LOCK_CNT <= 1) ? S_TRACK : S_PULL;
                            gc_n = GC_W'(1);
                            to_n = '0;
                        end else if (to_q == TO_LAST) begin
                            to_n  = '0;
                            idx_n = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                            fo_n  = sweep_off(idx_n);
                            ld_n  = 1'b1;
                        end else begin
                            to_n = to_q + 1'b1;
                        end
                    end
                end
                S_PULL: begin
                    if (eval) begin
                        if (good) begin
                            if (gc_q == GC_LAST) begin
                                st_n = S_TRACK;
                                gc_n = '0;
                                bc_n = '0;
                            end else begin
                                gc_n = gc_q + 1'b1;
                            end
                        end else begin
                            st_n = S_ACQ;
                            gc_n = '0;
                            to_n = '0;
                        end
                    end
                end
                default: begin
                    if (eval) begin
                        if (good) begin
                            bc_n = '0;
                        end else if (bc_q == BC_LAST) begin
                            // Lock lost: restart the sweep from zero offset.
                            st_n  = S_ACQ;
                            bc_n  = '0;
                            gc_n  = '0;
                            to_n  = '0;
                            idx_n = '0;
                            fo_n  = '0;
                            ld_n  = 1'b1;
                        end else begin
                            bc_n = bc_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State register plus outputs derived from the next state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            gc_q    <= '0;
            bc_q    <= '0;
            to_q    <= '0;
            idx_q   <= '0;
            fo_q    <= '0;
            ld_q    <= 1'b0;
            lk_q    <= 1'b0;
            kp_q    <= 4'(KP_ACQ);
            ki_q    <= 4'(KI_ACQ);
        end else begin
            state_q <= st_n;
            en_q    <= enable;
            gc_q    <= gc_n;
            bc_q    <= bc_n;
            to_q    <= to_n;
            idx_q   <= idx_n;
            fo_q    <= fo_n;
            ld_q    <= ld_n;
            lk_q    <= (st_n == S_TRACK);
            kp_q    <= (st_n == S_TRACK) ? 4'(KP_TRK) : 4'(KP_ACQ);
            ki_q    <= (st_n == S_TRACK) ? 4'(KI_TRK) : 4'(KI_ACQ);
        end
    end

    assign state            = state_q;
    assign kp_shift         = kp_q;
    assign ki_shift         = ki_q;
    assign freq_offset      = fo_q;
    assign freq_offset_load = ld_q;
    assign locked           = lk_q;
    assign win_done         = eval_q;

`ifdef COSTAS_ACQ_STATS_EN
    logic loss_ev;
    logic wrap_ev;

    assign loss_ev = (state_q == S_TRACK) && (st_n == S_ACQ);
    assign wrap_ev = ld_n && (state_q == S_ACQ) && (idx_q == IDX_LAST);

    // Saturating event counters, cleared by reset only.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lock_loss_cnt  <= '0;
            sweep_wrap_cnt <= '0;
        end else begin
            if (loss_ev && (lock_loss_cnt != '1)) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
            if (wrap_ev && (sweep_wrap_cnt != '1)) begin
                sweep_wrap_cnt <= sweep_wrap_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Bench for costas_acq_ctrl: window-level reference model feeding a scoreboard.
// Latency: expected outputs are compared on the cycle after each win_done pulse.
// Backpressure: none; stimulus drives one sample per cycle when active.
module tb_costas_acq_ctrl;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               enable;
    logic               sample_valid;
    logic signed [7:0]  i_data;
    logic signed [7:0]  q_data;
    logic [3:0]         kp_shift;
    logic [3:0]         ki_shift;
    logic signed [15:0] freq_offset;
    logic               freq_offset_load;
    logic               locked;
    logic [1:0]         state;
    logic               win_done;

    always #5 sys_clk = ~sys_clk;

    costas_acq_ctrl dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .enable           (enable),
        .sample_valid     (sample_valid),
        .i_data           (i_data),
        .q_data           (q_data),
        .kp_shift         (kp_shift),
        .ki_shift         (ki_shift),
        .freq_offset      (freq_offset),
        .freq_offset_load (freq_offset_load),
        .locked           (locked),
        .state            (state),
        .win_done         (win_done)
    );

    typedef struct {
        logic [1:0]         st;
        logic               lk;
        logic [3:0]         kp;
        logic [3:0]         ki;
        logic               ld;
        logic signed [15:0] fo;
    } exp_t;

    exp_t sbq[$];
    exp_t e_mon;
    int   errors = 0;
    int   checks = 0;

    // Reference model state (window granularity)
    int m_state = 0;
    int m_gc = 0, m_bc = 0, m_to = 0, m_idx = 0, m_freq = 0, m_loads = 0;
    int sc = 0, ai = 0, aq = 0, exp_wins = 0;
    int sweep_tab[5] = '{0, 100, -100, 200, -200};

    int obs_loads = 0;
    int obs_wins  = 0;
    bit chk_now   = 1'b0;

    function automatic int babs(input int v);
        int a;
        a = (v < 0) ? -v : v;
        if (a > 127) a = 127;
        return a;
    endfunction

    task automatic model_window();
        bit   good;
        bit   ld;
        exp_t x;
        good = (aq <= ai / 4) && (ai >= 256);
        ld   = 1'b0;
        case (m_state)
            1: begin
                if (good) begin
                    m_state = 2; m_gc = 1; m_to = 0;
                end else begin
                    m_to++;
                    if (m_to == 4) begin
                        m_idx  = (m_idx == 4) ? 0 : m_idx + 1;
                        m_freq = sweep_tab[m_idx];
                        ld     = 1'b1;
                        m_to   = 0;
                    end
                end
            end
            2: begin
                if (good) begin
                    m_gc++;
                    if (m_gc == 3) begin
                        m_state = 3; m_bc = 0; m_gc = 0;
                    end
                end else begin
                    m_state = 1; m_gc = 0; m_to = 0;
                end
            end
            3: begin
                if (good) begin
                    m_bc = 0;
                end else begin
                    m_bc++;
                    if (m_bc == 2) begin
                        m_state = 1; m_bc = 0; m_gc = 0; m_to = 0;
                        m_idx = 0; m_freq = 0; ld = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (ld) m_loads++;
        x.st = 2'(m_state);
        x.lk = (m_state == 3);
        x.kp = (m_state == 3) ? 4'd6 : 4'd3;
        x.ki = (m_state == 3) ? 4'd10 : 4'd6;
        x.ld = ld;
        x.fo = 16'(m_freq);
        sbq.push_back(x);
        exp_wins++;
    endtask

    // Drive n consecutive samples, one per cycle; the model sees each sample.
    task automatic drive(input int n, input int iv, input int qv);
        for (int k = 0; k < n; k++) begin
            sample_valid = 1'b1;
            i_data = 8'(iv);
            q_data = 8'(qv);
            sc++;
            ai += babs(iv);
            aq += babs(qv);
            if (sc == 16) begin
                model_window();
                sc = 0; ai = 0; aq = 0;
            end
            @(posedge sys_clk); #1;
        end
        sample_valid = 1'b0;
    endtask

    // Wait for all queued windows to be compared, bounded.
    task automatic drain();
        int t;
        t = 0;
        while ((sbq.size() != 0 || chk_now) && t < 60) begin
            @(posedge sys_clk); #1;
            t++;
        end
        if (t >= 60) begin
            errors++; checks++;
            $display("FAIL drain_timeout: %0d windows still pending, want 0", sbq.size());
        end
    endtask

    // Scoreboard: outputs compared one cycle after win_done; load pulses counted.
    always @(negedge sys_clk) begin
        if (freq_offset_load === 1'b1) obs_loads++;
        if (chk_now) begin
            chk_now = 1'b0;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL window_unexpected: win_done with no expected window");
            end else begin
                e_mon = sbq.pop_front();
                if (state !== e_mon.st || locked !== e_mon.lk || kp_shift !== e_mon.kp ||
                    ki_shift !== e_mon.ki || freq_offset_load !== e_mon.ld ||
                    freq_offset !== e_mon.fo) begin
                    errors++;
                    $display("FAIL window_outputs: got st=%0d lk=%0b kp=%0d ki=%0d ld=%0b fo=%0d want st=%0d lk=%0b kp=%0d ki=%0d ld=%0b fo=%0d",
                             state, locked, kp_shift, ki_shift, freq_offset_load, freq_offset,
                             e_mon.st, e_mon.lk, e_mon.kp, e_mon.ki, e_mon.ld, e_mon.fo);
                end
            end
        end
        if (win_done === 1'b1) begin
            obs_wins++;
            chk_now = 1'b1;
        end
    end

    task automatic test_reset();
        sys_rst = 1'b1; enable = 1'b1; sample_valid = 1'b0; i_data = '0; q_data = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge sys_clk); #1;
            checks++;
            if (state !== 2'd0 || kp_shift !== 4'd3 || ki_shift !== 4'd6 || freq_offset !== 16'sd0 ||
                freq_offset_load !== 1'b0 || locked !== 1'b0 || win_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_values: st=%0d kp=%0d ki=%0d fo=%0d ld=%0b lk=%0b wd=%0b want 0/3/6/0/0/0/0",
                         state, kp_shift, ki_shift, freq_offset, freq_offset_load, locked, win_done);
            end
        end
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("FAIL reset_release_1: state=%0d want 0", state);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL reset_release_2: state=%0d want 1", state);
        end
        m_state = 1;
    endtask

    task automatic test_lock();
        int l0;
        l0 = obs_loads;
        drive(48, 100, 10);
        drain();
        checks++;
        if (locked !== 1'b1 || kp_shift !== 4'd6 || ki_shift !== 4'd10 || state !== 2'd3) begin
            errors++;
            $display("FAIL lock_final: lk=%0b kp=%0d ki=%0d st=%0d want 1/6/10/3", locked, kp_shift, ki_shift, state);
        end
        checks++;
        if (obs_loads !== l0) begin
            errors++; $display("FAIL lock_no_load: loads=%0d want %0d", obs_loads, l0);
        end
    endtask

    task automatic test_unlock();
        drive(16, 80, 80);
        drain();
        checks++;
        if (locked !== 1'b1 || state !== 2'd3) begin
            errors++; $display("FAIL unlock_first_bad: lk=%0b st=%0d want 1/3", locked, state);
        end
        drive(16, 80, 80);
        drain();
        checks++;
        if (locked !== 1'b0 || state !== 2'd1 || kp_shift !== 4'd3 || freq_offset !== 16'sd0) begin
            errors++;
            $display("FAIL unlock_second_bad: lk=%0b st=%0d kp=%0d fo=%0d want 0/1/3/0", locked, state, kp_shift, freq_offset);
        end
    endtask

    task automatic test_sweep();
        int l0;
        l0 = obs_loads;
        drive(320, 50, 50);
        drain();
        checks++;
        if (obs_loads - l0 !== 5) begin
            errors++; $display("FAIL sweep_load_count: loads=%0d want 5", obs_loads - l0);
        end
        checks++;
        if (freq_offset !== 16'sd0 || state !== 2'd1) begin
            errors++; $display("FAIL sweep_wrapped: fo=%0d st=%0d want 0/1", freq_offset, state);
        end
    endtask

    task automatic test_saturate();
        drive(16, -128, 0);
        drain();
        checks++;
        if (state !== 2'd2) begin
            errors++; $display("FAIL sat_good: state=%0d want 2", state);
        end
        drive(16, 5, 0);
        drain();
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL small_amp_bad: state=%0d want 1", state);
        end
    endtask

    task automatic test_threshold();
        drive(16, 16, 4);   // accI=256, accQ=64: both limits met exactly
        drain();
        checks++;
        if (state !== 2'd2) begin
            errors++; $display("FAIL thr_edge_good: state=%0d want 2", state);
        end
        drive(16, 16, 5);   // accQ=80 > 64
        drain();
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL thr_q_bad: state=%0d want 1", state);
        end
        drive(16, 15, 0);   // accI=240 < 256
        drain();
    endtask

    task automatic test_enable();
        int g, l0, w0;
        g = 0;
        while (m_freq == 0 && g < 8) begin
            drive(16, 50, 50);
            g++;
        end
        drain();
        drive(7, 100, 10);
        l0 = obs_loads;
        enable = 1'b0;
        sc = 0; ai = 0; aq = 0;
        m_state = 0; m_gc = 0; m_bc = 0; m_to = 0;
        @(posedge sys_clk); #1;
        checks++;
        if (state !== 2'd0 || locked !== 1'b0 || kp_shift !== 4'd3 || win_done !== 1'b0 ||
            freq_offset !== 16'(m_freq)) begin
            errors++;
            $display("FAIL disable_outputs: st=%0d lk=%0b kp=%0d wd=%0b fo=%0d want 0/0/3/0/%0d",
                     state, locked, kp_shift, win_done, freq_offset, m_freq);
        end
        repeat (3) begin @(posedge sys_clk); #1; end
        enable = 1'b1;
        @(posedge sys_clk); #1;
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("FAIL reenable_1: state=%0d want 0", state);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL reenable_2: state=%0d want 1", state);
        end
        m_state = 1;
        checks++;
        if (obs_loads !== l0) begin
            errors++; $display("FAIL disable_no_load: loads=%0d want %0d", obs_loads, l0);
        end
        w0 = obs_wins;
        drive(15, 100, 10);
        repeat (3) begin @(posedge sys_clk); #1; end
        checks++;
        if (obs_wins !== w0) begin
            errors++; $display("FAIL stale_window: windows=%0d want %0d", obs_wins, w0);
        end
        drive(1, 100, 10);
        drain();
        checks++;
        if (state !== 2'd2) begin
            errors++; $display("FAIL fresh_window: state=%0d want 2", state);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_unlock();
        test_sweep();
        test_saturate();
        test_threshold();
        test_enable();
        checks++;
        if (obs_wins !== exp_wins) begin
            errors++; $display("FAIL window_count: got %0d want %0d", obs_wins, exp_wins);
        end
        checks++;
        if (obs_loads !== m_loads) begin
            errors++; $display("FAIL load_count: got %0d want %0d", obs_loads, m_loads);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
